iff_event_counter: RTL and testbench
====================================

IFF_EVENT_COUNTER -- requirements
Module: iff_event_counter

Interface
REQ-001 The block SHALL have parameter NCH, default 4, giving the number of independent event channels (1..32).
REQ-002 The block SHALL have parameter CW, default 8, giving the per-channel counter width in bits (2..32).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port ev, input, NCH bits: per-channel sampled event signal.
REQ-006 The block SHALL have port en, input, NCH bits: per-channel iff qualifier, evaluated in the same cycle as the edge.
REQ-007 The block SHALL have port edge_sel, input, 2*NCH bits: per-channel edge mode; 00 = none, 01 = rise, 10 = fall, 11 = both.
REQ-008 The block SHALL have port clr, input, NCH bits: per-channel synchronous clear of the count and overflow state.
REQ-009 The block SHALL have port cnt, output, NCH*CW bits: per-channel qualified-event count; channel i occupies bits [i*CW +: CW].
REQ-010 The block SHALL have port tog, output, NCH bits: per-channel toggle, inverted on every qualified event.
REQ-011 The block SHALL have port evt_vld, output, NCH bits: per-channel one-cycle registered pulse marking a qualified event.
REQ-012 The block SHALL have port ovf, output, NCH bits: per-channel sticky overflow flag.

Function
REQ-013 Each channel SHALL hold a registered copy ev_q of ev; rise = ev & ~ev_q; fall = ~ev & ev_q.
REQ-014 A qualified event SHALL occur in cycle t when the edge selected by edge_sel occurs in cycle t and en = 1 in cycle t; en in any other cycle SHALL have no effect.
REQ-015 A qualified event in cycle t SHALL update cnt, tog, evt_vld and ovf so that the new values are visible in cycle t+1 (latency 1).
REQ-016 evt_vld SHALL be 1 only in the cycle following a qualified event, and 0 otherwise.
REQ-017 In mode 11, a rise and a fall SHALL each count; an ev pulse one cycle wide SHALL therefore produce 2 counts in consecutive cycles.
REQ-018 If clr and a qualified event occur in the same cycle, clr SHALL win: cnt = 0 and ovf = 0, while tog still inverts and evt_vld still pulses.
REQ-019 clr SHALL NOT affect tog or ev_q.
REQ-020 A change of edge_sel SHALL take effect in the same cycle and SHALL NOT itself create an event.
REQ-021 Channels SHALL be fully independent; simultaneous events on all channels SHALL all be counted.

Reset
REQ-022 With rst = 1, cnt, tog, evt_vld and ovf SHALL be set to 0 at the next clock edge.
REQ-023 With rst = 1, ev_q SHALL load the current ev, so that a level held through reset produces no edge in the first cycle after reset.
REQ-024 A reset asserted mid-operation SHALL discard any event occurring in the same cycle.

Configuration
REQ-025 When macro IFF_EVENT_COUNTER_SAT_EN is defined, a counter at 2^CW-1 receiving a qualified event SHALL hold its value and set ovf.
REQ-026 When IFF_EVENT_COUNTER_SAT_EN is undefined, a counter at 2^CW-1 receiving a qualified event SHALL wrap to 0 and set ovf.
REQ-027 In both configurations, ovf SHALL remain set until clr or rst.

Structure
REQ-028 Package iff_event_pkg SHALL define an enumerated type for the edge_sel encoding (EDGE_NONE, EDGE_RISE, EDGE_FALL, EDGE_BOTH) and a function for counter width limits.
REQ-029 One sub-module, iff_event_chan, SHALL implement a single channel (edge detect, qualify, count, toggle, overflow).
REQ-030 iff_event_counter SHALL instantiate iff_event_chan NCH times in a generate loop.

Verification
REQ-031 Scenario, mode rise: channel 0 in mode 01 with en = 1 receives 5 ev pulses -> cnt[0] = 5, tog[0] = 1, and evt_vld[0] pulses 5 times, each one cycle after the corresponding rise.
REQ-032 Scenario, iff gating: channel 1 in mode 10 receives 4 falls with en = 1 only on the 2nd and 4th fall -> cnt[1] = 2 and tog[1] = 0.
REQ-033 Scenario, mode both: channel 2 in mode 11 receives three 1-cycle ev pulses -> cnt[2] = 6.
REQ-034 Scenario, boundary: with CW = 4, 16 qualified events -> cnt = 15 with ovf = 1 when SAT_EN is defined, or cnt = 0 with ovf = 1 when it is not.
REQ-035 Scenario, clear collision: clr[0] asserted in the same cycle as a qualified event with cnt[0] = 7 -> next cycle cnt[0] = 0, ovf[0] = 0, tog[0] inverted.
REQ-036 Scenario, reset: ev = all-ones held through rst, then rst released -> no evt_vld pulse, and all outputs are 0 until the first real edge.

Source files
------------

// File: rtl/iff_event_pkg.sv
// Shared types and helpers for the qualified event counter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   edge_sel_e  - per-channel edge mode encoding
//   CW_MIN/MAX  - legal counter width range
//   NCH_MIN/MAX - legal channel count range
//   cnt_max()   - largest value a CW-bit counter can hold
package iff_event_pkg;

   typedef enum logic [1:0] {
      EDGE_NONE = 2'b00,
      EDGE_RISE = 2'b01,
      EDGE_FALL = 2'b10,
      EDGE_BOTH = 2'b11
   } edge_sel_e;

   localparam int CW_MIN  = 2;
   localparam int CW_MAX  = 32;
   localparam int NCH_MIN = 1;
   localparam int NCH_MAX = 32;

   // Terminal count of a cw-bit counter. A 32-bit counter is handled
   // separately so the shift never runs off the end of a 32-bit word.
   function automatic logic [31:0] cnt_max(input int unsigned cw);
      if (cw >= 32)
         cnt_max = 32'hFFFF_FFFF;
      else
         cnt_max = (32'd1 << cw) - 32'd1;
   endfunction

endpackage

// File: rtl/iff_event_chan.sv
// One event channel: edge detect, en qualification, count, toggle, sticky overflow.
// Latency: 1 cycle from the qualifying edge to the cnt/tog/evt_vld/ovf update.
// Backpressure: none; every qualified event is taken in the cycle it occurs.
//
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   ev        - sampled event input
//   en        - qualifier, only looked at in the cycle the edge is seen
//   edge_sel  - EDGE_NONE / EDGE_RISE / EDGE_FALL / EDGE_BOTH
//   clr       - synchronous clear of cnt and ovf
//   cnt       - qualified event count
//   tog       - inverts on every qualified event
//   evt_vld   - one-cycle pulse after a qualified event
//   ovf       - sticky overflow
//
// Config: define IFF_EVENT_COUNTER_SAT_EN to saturate at the terminal count
// instead of wrapping to zero.
module iff_event_chan
   import iff_event_pkg::*;
#(
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ev,
   input  logic          en,
   input  logic [1:0]    edge_sel,
   input  logic          clr,
   output logic [CW-1:0] cnt,
   output logic          tog,
   output logic          evt_vld,
   output logic          ovf
);

   localparam logic [31:0]   CNT_MAX32 = cnt_max(CW);
   localparam logic [CW-1:0] CNT_MAX   = CNT_MAX32[CW-1:0];

   logic      ev_q;
   logic      rise;
   logic      fall;
   logic      edge_hit;
   logic      hit;
   edge_sel_e mode;

   assign mode = edge_sel_e'(edge_sel);
   assign rise = ev & ~ev_q;
   assign fall = ~ev & ev_q;

   // Mode is applied combinationally, so a change of edge_sel only
   // re-selects which edge is watched; it never manufactures one.
   always_comb begin
      edge_hit = 1'b0;
      case (mode)
         EDGE_NONE: edge_hit = 1'b0;
         EDGE_RISE: edge_hit = rise;
         EDGE_FALL: edge_hit = fall;
         EDGE_BOTH: edge_hit = rise | fall;
         default:   edge_hit = 1'b0;
      endcase
   end

   assign hit = edge_hit & en;

   always_ff @(posedge clk) begin
      // ev_q tracks ev even in reset so a level held through reset
      // looks like a steady level, not an edge, on the first cycle out.
      ev_q <= ev;
      if (rst) begin
         cnt     <= '0;
         tog     <= 1'b0;
         evt_vld <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         evt_vld <= hit;
         if (hit)
            tog <= ~tog;
         // clr wins over a coincident event for cnt/ovf only; tog and
         // evt_vld still report the event above.
         if (clr) begin
            cnt <= '0;
            ovf <= 1'b0;
         end else if (hit) begin
            if (cnt == CNT_MAX) begin
               ovf <= 1'b1;
`ifdef IFF_EVENT_COUNTER_SAT_EN
               cnt <= cnt;
`else
               cnt <= '0;
`endif
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/iff_event_counter.sv
// Bank of NCH independent qualified edge counters, one iff_event_chan each.
// Latency: 1 cycle from qualifying edge to updated outputs.
// Backpressure: none; all channels accept an event every cycle.
//
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   ev[NCH]   - event inputs
//   en[NCH]   - per-channel qualifiers
//   edge_sel  - 2 bits per channel, channel i at [2*i +: 2]
//   clr[NCH]  - per-channel clear of count and overflow
//   cnt       - CW bits per channel, channel i at [i*CW +: CW]
//   tog, evt_vld, ovf - 1 bit per channel
//
// Config: IFF_EVENT_COUNTER_SAT_EN selects saturating counters (default wraps).
module iff_event_counter
   import iff_event_pkg::*;
#(
   parameter int NCH = 4,
   parameter int CW  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NCH-1:0]    ev,
   input  logic [NCH-1:0]    en,
   input  logic [2*NCH-1:0]  edge_sel,
   input  logic [NCH-1:0]    clr,
   output logic [NCH*CW-1:0] cnt,
   output logic [NCH-1:0]    tog,
   output logic [NCH-1:0]    evt_vld,
   output logic [NCH-1:0]    ovf
);

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      iff_event_chan #(
         .CW (CW)
      ) u_chan (
         .clk      (clk),
         .rst      (rst),
         .ev       (ev[i]),
         .en       (en[i]),
         .edge_sel (edge_sel[2*i +: 2]),
         .clr      (clr[i]),
         .cnt      (cnt[i*CW +: CW]),
         .tog      (tog[i]),
         .evt_vld  (evt_vld[i]),
         .ovf      (ovf[i])
      );
   end

endmodule

// File: tb/tb_iff_event_counter.sv
// Directed bench for iff_event_counter (NCH=4, CW=4) with a per-cycle
// reference model feeding an expected-value queue, plus fixed scenario checks.
module tb_iff_event_counter;

   localparam int NCH = 4;
   localparam int CW  = 4;
   localparam logic [CW-1:0] TOP = 4'd15;

   logic              clk = 1'b0;
   logic              rst;
   logic [NCH-1:0]    ev;
   logic [NCH-1:0]    en;
   logic [2*NCH-1:0]  edge_sel;
   logic [NCH-1:0]    clr;
   logic [NCH*CW-1:0] cnt;
   logic [NCH-1:0]    tog;
   logic [NCH-1:0]    evt_vld;
   logic [NCH-1:0]    ovf;

   iff_event_counter #(.NCH(NCH), .CW(CW)) dut (
      .clk      (clk),
      .rst      (rst),
      .ev       (ev),
      .en       (en),
      .edge_sel (edge_sel),
      .clr      (clr),
      .cnt      (cnt),
      .tog      (tog),
      .evt_vld  (evt_vld),
      .ovf      (ovf)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [NCH*CW-1:0] cnt;
      logic [NCH-1:0]    tog;
      logic [NCH-1:0]    vld;
      logic [NCH-1:0]    ovf;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   vcnt0  = 0;

   // reference state
   logic [NCH-1:0] m_evq;
   logic [NCH-1:0] m_tog;
   logic [NCH-1:0] m_vld;
   logic [NCH-1:0] m_ovf;
   logic [CW-1:0]  m_cnt [NCH];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance the model by one clock using the inputs currently driven.
   task automatic model_push();
      exp_t e;
      for (int i = 0; i < NCH; i++) begin
         logic r, f, hit;
         logic [1:0] s;
         r   = ev[i] & ~m_evq[i];
         f   = ~ev[i] & m_evq[i];
         s   = edge_sel[2*i +: 2];
         hit = en[i] & ((s == 2'b01 && r) || (s == 2'b10 && f) || (s == 2'b11 && (r || f)));
         m_evq[i] = ev[i];
         if (rst) begin
            m_cnt[i] = '0;
            m_tog[i] = 1'b0;
            m_vld[i] = 1'b0;
            m_ovf[i] = 1'b0;
         end else begin
            m_vld[i] = hit;
            if (hit) m_tog[i] = ~m_tog[i];
            if (clr[i]) begin
               m_cnt[i] = '0;
               m_ovf[i] = 1'b0;
            end else if (hit) begin
               if (m_cnt[i] == TOP) begin
                  m_ovf[i] = 1'b1;
`ifdef IFF_EVENT_COUNTER_SAT_EN
                  m_cnt[i] = TOP;
`else
                  m_cnt[i] = '0;
`endif
               end else begin
                  m_cnt[i] = m_cnt[i] + 4'd1;
               end
            end
         end
         e.cnt[i*CW +: CW] = m_cnt[i];
      end
      e.tog = m_tog;
      e.vld = m_vld;
      e.ovf = m_ovf;
      sb.push_back(e);
   endtask

   // One clock: predict, clock the DUT, compare away from the edge.
   task automatic cyc();
      exp_t e;
      model_push();
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL sb_empty observed=0 expected=1");
      end else begin
         e = sb.pop_front();
         chk("cnt", cnt, e.cnt);
         chk("tog", tog, e.tog);
         chk("evt_vld", evt_vld, e.vld);
         chk("ovf", ovf, e.ovf);
      end
      if (evt_vld[0] === 1'b1) vcnt0++;
   endtask

   function automatic logic [CW-1:0] ch(input int i);
      return cnt[i*CW +: CW];
   endfunction

   initial begin
      // reset with ev held high
      rst = 1'b1; ev = '1; en = '0; edge_sel = '0; clr = '0;
      cyc(); cyc();
      chk("reset_cnt", cnt, 0);
      rst = 1'b0; edge_sel = 8'hFF; en = '1;
      cyc();
      chk("post_reset_no_vld", evt_vld, 0);
      cyc();
      chk("post_reset_cnt", cnt, 0);
      chk("post_reset_tog", tog, 0);
      chk("post_reset_ovf", ovf, 0);

      // drop ev with detection off, then switch modes on a steady ev
      edge_sel = '0; ev = '0; cyc();
      en = '0; cyc();
      edge_sel = 8'hFF; en = '1; cyc();
      chk("sel_change_no_evt", evt_vld, 0);

      // mode rise on channel 0
      edge_sel = 8'b00_00_00_01; en = 4'b0001; vcnt0 = 0;
      repeat (5) begin
         ev[0] = 1'b1; cyc();
         chk("rise_vld_after_edge", evt_vld[0], 1);
         ev[0] = 1'b0; cyc();
         chk("rise_vld_one_cycle", evt_vld[0], 0);
      end
      chk("rise_cnt0", ch(0), 5);
      chk("rise_tog0", tog[0], 1);
      chk("rise_pulses", vcnt0, 5);

      // fall mode on channel 1, en only on 2nd and 4th fall
      edge_sel = 8'b00_00_10_00;
      for (int k = 0; k < 4; k++) begin
         ev[1] = 1'b1; en = '0; cyc();
         ev[1] = 1'b0; en[1] = (k == 1 || k == 3); cyc();
      end
      en = '0; cyc();
      chk("iff_cnt1", ch(1), 2);
      chk("iff_tog1", tog[1], 0);

      // both edges on channel 2
      edge_sel = 8'b00_11_00_00; en = 4'b0100;
      repeat (3) begin
         ev[2] = 1'b1; cyc();
         ev[2] = 1'b0; cyc();
      end
      chk("both_cnt2", ch(2), 6);

      // terminal count on channel 3
      edge_sel = 8'b01_00_00_00; en = 4'b1000; clr = 4'b1000; cyc();
      clr = '0;
      repeat (16) begin
         ev[3] = 1'b1; cyc();
         ev[3] = 1'b0; cyc();
      end
`ifdef IFF_EVENT_COUNTER_SAT_EN
      chk("bound_cnt3", ch(3), 15);
`else
      chk("bound_cnt3", ch(3), 0);
`endif
      chk("bound_ovf3", ovf[3], 1);
      ev[3] = 1'b1; cyc();
      ev[3] = 1'b0; cyc();
      chk("ovf3_sticky", ovf[3], 1);

      // clear colliding with an event on channels 0 and 3
      edge_sel = 8'b01_00_00_01; en = 4'b1001; clr = 4'b0001; cyc();
      clr = '0;
      repeat (7) begin
         ev[0] = 1'b1; cyc();
         ev[0] = 1'b0; cyc();
      end
      chk("pre_clr_cnt0", ch(0), 7);
      ev[0] = 1'b1; ev[3] = 1'b1; clr = 4'b1001; cyc();
      chk("clr_cnt0", ch(0), 0);
      chk("clr_ovf0", ovf[0], 0);
      chk("clr_tog0", tog[0], 1);
      chk("clr_vld0", evt_vld[0], 1);
      chk("clr_cnt3", ch(3), 0);
      chk("clr_ovf3", ovf[3], 0);
      clr = '0; ev = '0; cyc();

      // simultaneous rise on every channel
      edge_sel = 8'h55; en = '1; clr = '1; cyc();
      clr = '0; ev = '1; cyc();
      chk("all_vld", evt_vld, 4'hF);
      chk("all_cnt", cnt, 16'h1111);
      ev = '0; cyc();

      // reset on top of an edge discards it
      ev = '1; rst = 1'b1; cyc();
      chk("midrst_vld", evt_vld, 0);
      chk("midrst_cnt", cnt, 0);
      rst = 1'b0; cyc();
      chk("midrst_no_edge", evt_vld, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
